// File: rtl/memgame_pkg.sv
// Shared memory-game types: turn timer state encoding and turn-length limit.
package memgame_pkg;

  // Largest turn length representable in the 5-bit seconds counter.
  localparam int unsigned MAX_TURN_SECONDS = 31;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } timer_state_t;

endpackage

// File: rtl/turn_timer_if.sv
// Turn timer control/status bundle. The master drives turn_start/pause and
// observes the countdown; the slave (turn_timer) does the reverse.
interface turn_timer_if;
  logic       turn_start;
  logic       pause;
  logic       timeUp;
  logic [4:0] seconds_left;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;
  logic       running;

  modport master (
    output turn_start,
    output pause,
    input  timeUp,
    input  seconds_left,
    input  bcd_tens,
    input  bcd_ones,
    input  running
  );

  modport slave (
    input  turn_start,
    input  pause,
    output timeUp,
    output seconds_left,
    output bcd_tens,
    output bcd_ones,
    output running
  );
endinterface

// File: rtl/bin2bcd5.sv
// 5-bit binary (0..31) to two BCD digits, purely combinational.
module bin2bcd5 (
  input  logic [4:0] bin_i,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o
);

  // Range compare instead of divide: only four possible tens values.
  always_comb begin
    tens_o = '0;
    ones_o = bin_i[3:0];
    if (bin_i >= 5'd30) begin
      tens_o = 4'd3;
      ones_o = 4'(bin_i - 5'd30);
    end else if (bin_i >= 5'd20) begin
      tens_o = 4'd2;
      ones_o = 4'(bin_i - 5'd20);
    end else if (bin_i >= 5'd10) begin
      tens_o = 4'd1;
      ones_o = 4'(bin_i - 5'd10);
    end
  end

endmodule

// File: rtl/turn_timer.sv
// Per-turn countdown for the memory game. Counts whole seconds from a
// turn_start pulse and emits a one-cycle timeUp pulse on expiry.
// Optional feature: define TURN_TIMER_AUTORESTART_EN to reload the countdown
// automatically one cycle after each timeUp pulse instead of stopping.
module turn_timer
  import memgame_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned TURN_SECONDS = 15
) (
  input logic         clk,
  input logic         rst,
  turn_timer_if.slave bus
);

  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_TC = PW'(CLK_HZ - 1);
  // Out-of-range turn lengths saturate to what the 5-bit counter can hold.
  localparam logic [4:0] RELOAD_SECS =
    (TURN_SECONDS > MAX_TURN_SECONDS) ? 5'(MAX_TURN_SECONDS) : 5'(TURN_SECONDS);

  timer_state_t  state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [4:0]    secs_q,  secs_d;
  logic          timeup_q, timeup_d;
  logic [3:0]    bcd_tens, bcd_ones;

  // State, prescaler, seconds and timeUp registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      secs_q   <= '0;
      timeup_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      secs_q   <= secs_d;
      timeup_q <= timeup_d;
    end
  end

  // Next-state logic; priority turn_start > (auto-reload) > pause > count.
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    secs_d   = secs_q;
    timeup_d = 1'b0;

    if (bus.turn_start) begin
      state_d = RUN;
      presc_d = '0;
      secs_d  = RELOAD_SECS;
`ifdef TURN_TIMER_AUTORESTART_EN
    end else if (timeup_q) begin
      // The cycle after the pulse reloads, staying in RUN throughout.
      state_d = RUN;
      presc_d = '0;
      secs_d  = RELOAD_SECS;
`endif
    end else if (state_q == RUN && !bus.pause) begin
      if (presc_q == PRESC_TC) begin
        presc_d = '0;
        if (secs_q != '0) begin
          secs_d = secs_q - 5'd1;
          if (secs_q == 5'd1) begin
            timeup_d = 1'b1;
`ifdef TURN_TIMER_AUTORESTART_EN
            state_d  = RUN;
`else
            state_d  = EXPIRED;
`endif
          end
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  bin2bcd5 u_bcd (
    .bin_i  (secs_q),
    .tens_o (bcd_tens),
    .ones_o (bcd_ones)
  );

  assign bus.timeUp       = timeup_q;
  assign bus.seconds_left = secs_q;
  assign bus.bcd_tens     = bcd_tens;
  assign bus.bcd_ones     = bcd_ones;
  assign bus.running      = (state_q == RUN);

endmodule

// File: tb/tb_turn_timer.sv
// Scoreboard bench for turn_timer. The reference model tracks the absolute
// edge at which the turn expires and derives the remaining seconds from it.
module tb_turn_timer;

  localparam int unsigned CLK_HZ       = 4;
  localparam int unsigned TURN_SECONDS = 3;

  logic clk = 1'b0;
  logic rst;

  turn_timer_if ifc ();

  turn_timer #(
    .CLK_HZ       (CLK_HZ),
    .TURN_SECONDS (TURN_SECONDS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    bit          tu;
    bit          run;
    int unsigned secs;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state
  int unsigned edge_n    = 0;
  bit          m_run     = 1'b0;
  bit          m_prev_tu = 1'b0;
  int unsigned expire_at = 0;

  function automatic void chk(input string nm, input int unsigned cyc,
                              input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%0d exp=%0d", nm, cyc, got, exp);
    end
  endfunction

  // Apply one edge worth of inputs, advance the model, queue the expectation.
  task automatic step(input bit r, input bit ts, input bit pz);
    exp_t e;
    rst            = r;
    ifc.turn_start = ts;
    ifc.pause      = pz;
    e.cyc = edge_n;
    e.tu  = 1'b0;
    if (r) begin
      m_run = 1'b0;
    end else if (ts) begin
      m_run     = 1'b1;
      expire_at = edge_n + TURN_SECONDS * CLK_HZ;
`ifdef TURN_TIMER_AUTORESTART_EN
    end else if (m_prev_tu) begin
      expire_at = edge_n + TURN_SECONDS * CLK_HZ;
`endif
    end else if (m_run) begin
      if (pz) begin
        expire_at++;
      end else if (edge_n == expire_at) begin
        e.tu = 1'b1;
`ifndef TURN_TIMER_AUTORESTART_EN
        m_run = 1'b0;
`endif
      end
    end
    m_prev_tu = e.tu;
    e.run  = m_run;
    e.secs = m_run ? (expire_at - edge_n + CLK_HZ - 1) / CLK_HZ : 0;
    sb.push_back(e);
    edge_n++;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: compare DUT outputs against the queued expectation for each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("timeUp",       e.cyc, 32'(ifc.timeUp),       32'(e.tu));
        chk("running",      e.cyc, 32'(ifc.running),      32'(e.run));
        chk("seconds_left", e.cyc, 32'(ifc.seconds_left), e.secs);
        chk("bcd_tens",     e.cyc, 32'(ifc.bcd_tens),     e.secs / 10);
        chk("bcd_ones",     e.cyc, 32'(ifc.bcd_ones),     e.secs % 10);
      end
    end
  end

  // Driver: directed scenarios, then randomized traffic.
  initial begin
    bit pz_lvl;
    bit ts_r;
    bit rst_r;
    pz_lvl = 1'b0;

    step(1, 0, 0);
    step(1, 0, 0);
    repeat (50) step(0, 0, 0);

    // Plain countdown to expiry.
    step(0, 1, 0);
    repeat (16) step(0, 0, 0);

    // Re-pulse at relative edge 6.
    step(0, 1, 0);
    repeat (5) step(0, 0, 0);
    step(0, 1, 0);
    repeat (16) step(0, 0, 0);

    // Pause over relative edges 5..9.
    step(0, 1, 0);
    repeat (4) step(0, 0, 0);
    repeat (5) step(0, 0, 1);
    repeat (12) step(0, 0, 0);

    // turn_start coincident with the final tick.
    step(0, 1, 0);
    repeat (11) step(0, 0, 0);
    step(0, 1, 0);
    repeat (16) step(0, 0, 0);

    // turn_start while paused: reload frozen, counting resumes on release.
    step(0, 0, 1);
    step(0, 1, 1);
    repeat (3) step(0, 0, 1);
    repeat (14) step(0, 0, 0);

    // Randomized traffic.
    for (int unsigned i = 0; i < 3000; i++) begin
      if ($urandom_range(11, 0) == 0) pz_lvl = ~pz_lvl;
      ts_r  = ($urandom_range(24, 0) == 0);
      rst_r = ($urandom_range(599, 0) == 0);
      step(rst_r, ts_r, pz_lvl);
    end
    repeat (4) step(0, 0, 0);

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
